// File: rtl/dm_hart_ctl_if.sv
// Debug-module run-control signal bundle: the DMI-side DMCONTROL write strobe,
// the hart's halt/reset indications, and the run-control outputs.
interface dm_hart_ctl_if;
  logic        dmcontrol_write;
  logic [31:0] dmcontrol_wdata;
  logic        hart_halted;
  logic        hart_reset;
  logic        halt_req;
  logic        resume_req;
  logic        dmactive;
  logic        ndmreset;
  logic        haltreq_rb;
  logic        st_halted;
  logic        st_running;
  logic        st_resumeack;
  logic        st_havereset;
  logic        resume_err;

  modport master (
    output dmcontrol_write, dmcontrol_wdata, hart_halted, hart_reset,
    input  halt_req, resume_req, dmactive, ndmreset, haltreq_rb,
           st_halted, st_running, st_resumeack, st_havereset, resume_err
  );

  modport slave (
    input  dmcontrol_write, dmcontrol_wdata, hart_halted, hart_reset,
    output halt_req, resume_req, dmactive, ndmreset, haltreq_rb,
           st_halted, st_running, st_resumeack, st_havereset, resume_err
  );
endinterface

// File: rtl/dm_hart_ctl.sv
// Debug Module run control for a single hart: DMCONTROL halt/resume bits,
// halt/resume handshake with the hart, and DMSTATUS run-control fields.
module dm_hart_ctl #(
  parameter int unsigned RESUME_TIMEOUT = 1024
) (
  input logic          clk,
  input logic          rst,
  dm_hart_ctl_if.slave dm
);

  localparam int unsigned CNT_W    = (RESUME_TIMEOUT > 1) ? $clog2(RESUME_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESUME_TIMEOUT - 1);
  localparam int unsigned B_HALTREQ   = 31;
  localparam int unsigned B_RESUMEREQ = 30;
  localparam int unsigned B_ACKHAVERST = 28;
  localparam int unsigned B_NDMRESET  = 1;
  localparam int unsigned B_DMACTIVE  = 0;

  typedef enum logic [1:0] {
    ST_RUNNING  = 2'd0,
    ST_HALTED   = 2'd1,
    ST_RESUMING = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic dmactive_q, dmactive_d;
  logic haltreq_q, haltreq_d;
  logic ndmreset_q, ndmreset_d;
  logic resumeack_q, resumeack_d;
  logic resume_err_q, resume_err_d;
  logic havereset_q, havereset_d;
  logic st_halted_q, st_halted_d;
  logic st_running_q, st_running_d;

  logic wr_active, wr_deact, resume_cmd;
  logic wdata_unused;

  assign wdata_unused = ^{dm.dmcontrol_wdata[29], dm.dmcontrol_wdata[27:2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUNNING;
      cnt_q        <= '0;
      dmactive_q   <= 1'b0;
      haltreq_q    <= 1'b0;
      ndmreset_q   <= 1'b0;
      resumeack_q  <= 1'b0;
      resume_err_q <= 1'b0;
      havereset_q  <= 1'b1;
      st_halted_q  <= 1'b0;
      st_running_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dmactive_q   <= dmactive_d;
      haltreq_q    <= haltreq_d;
      ndmreset_q   <= ndmreset_d;
      resumeack_q  <= resumeack_d;
      resume_err_q <= resume_err_d;
      havereset_q  <= havereset_d;
      st_halted_q  <= st_halted_d;
      st_running_q <= st_running_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dmactive_d   = dmactive_q;
    haltreq_d    = haltreq_q;
    ndmreset_d   = ndmreset_q;
    resumeack_d  = resumeack_q;
    resume_err_d = resume_err_q;
    havereset_d  = havereset_q;

    // Control bits are only accepted once the module is already active.
    wr_active  = dm.dmcontrol_write & dmactive_q & dm.dmcontrol_wdata[B_DMACTIVE];
    wr_deact   = dm.dmcontrol_write & ~dm.dmcontrol_wdata[B_DMACTIVE];
    resume_cmd = wr_active & dm.dmcontrol_wdata[B_RESUMEREQ] & ~dm.dmcontrol_wdata[B_HALTREQ];

    if (dm.dmcontrol_write & dm.dmcontrol_wdata[B_DMACTIVE]) dmactive_d = 1'b1;
    if (wr_active) begin
      haltreq_d  = dm.dmcontrol_wdata[B_HALTREQ];
      ndmreset_d = dm.dmcontrol_wdata[B_NDMRESET];
      if (dm.dmcontrol_wdata[B_ACKHAVERST]) havereset_d = 1'b0;
    end
    if (dm.hart_reset) havereset_d = 1'b1;

    case (state_q)
      ST_RUNNING: begin
        if (dm.hart_halted) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (resume_cmd) begin
          resumeack_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_RESUMING;
        end else if (!dm.hart_halted) begin
          state_d = ST_RUNNING;
        end
      end
      ST_RESUMING: begin
        if (!dm.hart_halted) begin
          resumeack_d = 1'b1;
          state_d     = ST_RUNNING;
        end else if (cnt_q == CNT_LAST) begin
          resume_err_d = 1'b1;
          state_d      = ST_HALTED;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_RUNNING;
    endcase

    // A hart reset aborts any handshake in flight; haltreq stays as written.
    if (dm.hart_reset) begin
      state_d = dm.hart_halted ? ST_HALTED : ST_RUNNING;
      cnt_d   = '0;
    end

    if (wr_deact) begin
      dmactive_d   = 1'b0;
      haltreq_d    = 1'b0;
      ndmreset_d   = 1'b0;
      resumeack_d  = 1'b0;
      resume_err_d = 1'b0;
      cnt_d        = '0;
      state_d      = ST_RUNNING;
    end

    st_halted_d  = dmactive_d & dm.hart_halted;
    st_running_d = dmactive_d & ~dm.hart_halted;
  end

  // halt_req is never raised while the hart is already halted or being resumed.
  assign dm.halt_req     = dmactive_q & haltreq_q & ~dm.hart_halted & (state_q != ST_RESUMING);
  assign dm.resume_req   = dmactive_q & (state_q == ST_RESUMING);
  assign dm.dmactive     = dmactive_q;
  assign dm.ndmreset     = ndmreset_q;
  assign dm.haltreq_rb   = haltreq_q;
  assign dm.st_halted    = st_halted_q;
  assign dm.st_running   = st_running_q;
  assign dm.st_resumeack = resumeack_q;
  assign dm.st_havereset = havereset_q;
  assign dm.resume_err   = resume_err_q;

endmodule
